aidan_mcnay_div_arbiter: RTL and testbench
==========================================

AIDAN_MCNAY_DIV_ARBITER -- requirements
Module: aidan_mcnay_div_arbiter

Interface
REQ-001 SHALL have parameter nbits, default 32, operand and result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_val  input  2  request valid per requester (bit i = requester i).
REQ-005 SHALL have port req_rdy  output  2  request accept per requester.
REQ-006 SHALL have port req_opa  input  2*nbits  dividend, requester i in bits [i*nbits +: nbits].
REQ-007 SHALL have port req_opb  input  2*nbits  divisor, same packing as req_opa.
REQ-008 SHALL have port resp_val  output  2  response valid per requester.
REQ-009 SHALL have port resp_rdy  input  2  response accept per requester.
REQ-010 SHALL have port resp_result  output  nbits  latched divider result, shared by both responses.
REQ-011 SHALL have ports div_opa, div_opb  output  nbits  operands to the divider.
REQ-012 SHALL have ports div_istream_val (output, 1) and div_istream_rdy (input, 1), divider input handshake.
REQ-013 SHALL have ports div_ostream_val (input, 1), div_ostream_rdy (output, 1) and div_result (input, nbits), divider output handshake.
REQ-014 SHALL have port owner  output  1  index of the requester currently holding the divider.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if any req_val bit is set, SHALL grant one requester, assert its req_rdy combinationally, latch its opa/opb and its index into owner, and go to ISSUE.
REQ-017 Grant rule: if both are valid, SHALL grant requester ptr; if only one is valid, SHALL grant that one regardless of ptr.
REQ-018 ISSUE: SHALL drive div_istream_val=1 with the latched operands; on div_istream_rdy=1 SHALL go to WAIT. Operands SHALL stay stable while stalled.
REQ-019 WAIT: SHALL drive div_ostream_rdy=1; on div_ostream_val=1 SHALL latch div_result and go to RESP.
REQ-020 RESP: SHALL drive resp_val[owner]=1 with resp_result stable; on resp_rdy[owner]=1 SHALL go to IDLE and set ptr to ~owner.
REQ-021 req_rdy SHALL be 0 outside IDLE. div_istream_val SHALL be 0 outside ISSUE. div_ostream_rdy SHALL be 0 outside WAIT.
REQ-022 resp_val[~owner] SHALL always be 0. div_ostream_val outside WAIT SHALL be ignored.
REQ-023 Minimum latency from request accept to resp_val SHALL be 2 cycles plus the divider latency: accept at cycle T, div issue at T+1, resp_val one cycle after div_ostream_val.
REQ-024 Operands (including opb=0) SHALL be forwarded unmodified; divide-by-zero handling belongs to the divider.
REQ-025 At most one transaction SHALL be outstanding; there is no queueing.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, ptr=0, owner=0, and clear the latched operands and result to 0.
REQ-027 While reset=0, all outputs SHALL be 0, including req_rdy, resp_val, div_istream_val and div_ostream_rdy.
REQ-028 Reset mid-transaction SHALL abandon that transaction with no response issued; the divider shares the same reset.

Structure
REQ-029 FSM state encodings (2-bit) and the requester count constant (2) SHALL live in the shared include file aidan_mcnay_div_arb_defs.
REQ-030 Grant logic SHALL be a sub-module, aidan_mcnay_rr_arb2 (inputs req[1:0] and ptr; output grant index and a grant-valid flag), which is purely combinational.

Verification (bench divider model returns opa % opb after 4 cycles; nbits=32)
REQ-031 req0 opa=35, opb=5 -> one resp_val[0] pulse with resp_result=0; resp_val[1] never asserted.
REQ-032 Both valid after reset, req0 (7,3) and req1 (9,2) -> req0 served first with result 1, then req1 with result 1; owner 0 then 1.
REQ-033 req1 held valid for two transactions (10,4), then (11,4), req0 idle -> results 2 then 3, served back to back with no idle grant gap.
REQ-034 resp_rdy[0]=0 for 5 cycles in RESP -> resp_val[0] held, resp_result stable, req_rdy[1]=0 throughout.
REQ-035 div_istream_rdy=0 for 3 cycles in ISSUE -> div_istream_val held and div_opa/div_opb unchanged.
REQ-036 reset asserted in WAIT -> all outputs 0 in the same cycle; after release, both valid -> requester 0 granted first.

Source files
------------

// File: rtl/aidan_mcnay_div_arb_defs.sv
`default_nettype none
// ============================================================================
// Module   : aidan_mcnay_div_arb_defs (package)
// Purpose  : Shared FSM encodings and requester count for the divider arbiter.
// Revision : 1.0
// ============================================================================
package aidan_mcnay_div_arb_defs;

  localparam int unsigned NUM_REQ = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/aidan_mcnay_div_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : aidan_mcnay_rr_arb2
// Purpose  : Two-way combinational grant; ptr breaks ties when both request.
// Revision : 1.0
// ============================================================================
module aidan_mcnay_rr_arb2
  import aidan_mcnay_div_arb_defs::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic               grant,
  output logic               grant_val
);

  always_comb begin
    grant_val = |req;
    if (req == 2'b11) grant = ptr;
    else              grant = req[1];
  end

endmodule

`default_nettype wire

// File: rtl/aidan_mcnay_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aidan_mcnay_div_arbiter
// Purpose  : Shares one iterative divider between two requesters, one
//            transaction in flight at a time.
// Revision : 1.0
// ============================================================================
module aidan_mcnay_div_arbiter
  import aidan_mcnay_div_arb_defs::*;
#(
  parameter int nbits = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_val,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic [NUM_REQ*nbits-1:0] req_opa,
  input  logic [NUM_REQ*nbits-1:0] req_opb,
  output logic [NUM_REQ-1:0]       resp_val,
  input  logic [NUM_REQ-1:0]       resp_rdy,
  output logic [nbits-1:0]         resp_result,
  output logic [nbits-1:0]         div_opa,
  output logic [nbits-1:0]         div_opb,
  output logic                     div_istream_val,
  input  logic                     div_istream_rdy,
  input  logic                     div_ostream_val,
  output logic                     div_ostream_rdy,
  input  logic [nbits-1:0]         div_result,
  output logic                     owner
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_ptr;
  logic             r_owner;
  logic [nbits-1:0] r_opa;
  logic [nbits-1:0] r_opb;
  logic [nbits-1:0] r_result;

  logic             w_grant;
  logic             w_grant_val;
  logic [nbits-1:0] w_sel_opa;
  logic [nbits-1:0] w_sel_opb;
  logic             w_accept;
  logic             w_done;

  aidan_mcnay_rr_arb2 u_rr_arb2 (
    .req       (req_val),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_val (w_grant_val)
  );

  always_comb begin
    w_sel_opa = w_grant ? req_opa[2*nbits-1:nbits] : req_opa[nbits-1:0];
    w_sel_opb = w_grant ? req_opb[2*nbits-1:nbits] : req_opb[nbits-1:0];
    w_accept  = (r_state == ST_IDLE) && w_grant_val;
    w_done    = (r_state == ST_RESP) && resp_rdy[r_owner];
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant_val)       w_state_next = ST_ISSUE;
      ST_ISSUE: if (div_istream_rdy)   w_state_next = ST_WAIT;
      ST_WAIT:  if (div_ostream_val)   w_state_next = ST_RESP;
      ST_RESP:  if (resp_rdy[r_owner]) w_state_next = ST_IDLE;
      default:                         w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; the reset term keeps handshakes quiet while reset is held
  always_comb begin
    req_rdy         = '0;
    resp_val        = '0;
    div_istream_val = 1'b0;
    div_ostream_rdy = 1'b0;
    if (reset) begin
      case (r_state)
        ST_IDLE:  req_rdy[w_grant]   = w_grant_val;
        ST_ISSUE: div_istream_val    = 1'b1;
        ST_WAIT:  div_ostream_rdy    = 1'b1;
        ST_RESP:  resp_val[r_owner]  = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant;
        r_opa   <= w_sel_opa;
        r_opb   <= w_sel_opb;
      end
      if ((r_state == ST_WAIT) && div_ostream_val) r_result <= div_result;
      // Favour the other requester on the next tie
      if (w_done) r_ptr <= ~r_owner;
    end
  end

  always_comb begin
    div_opa     = r_opa;
    div_opb     = r_opb;
    resp_result = r_result;
    owner       = r_owner;
  end

endmodule

`default_nettype wire

// File: tb/tb_aidan_mcnay_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aidan_mcnay_div_arbiter
// Purpose  : Directed self-checking bench with a 4-cycle opa%opb divider model.
// Revision : 1.0
// ============================================================================
module tb_aidan_mcnay_div_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic [63:0] req_opa;
  logic [63:0] req_opb;
  logic [1:0]  resp_val;
  logic [1:0]  resp_rdy;
  logic [31:0] resp_result;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        div_istream_val;
  logic        div_istream_rdy;
  logic        div_ostream_val;
  logic        div_ostream_rdy;
  logic [31:0] div_result;
  logic        owner;

  int total = 0;
  int bad   = 0;
  logic seen1;
  logic seen_both;

  always #5 clk = ~clk;

  aidan_mcnay_div_arbiter #(.nbits(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .req_opa         (req_opa),
    .req_opb         (req_opb),
    .resp_val        (resp_val),
    .resp_rdy        (resp_rdy),
    .resp_result     (resp_result),
    .div_opa         (div_opa),
    .div_opb         (div_opb),
    .div_istream_val (div_istream_val),
    .div_istream_rdy (div_istream_rdy),
    .div_ostream_val (div_ostream_val),
    .div_ostream_rdy (div_ostream_rdy),
    .div_result      (div_result),
    .owner           (owner)
  );

  // Divider model: accepts one operand pair, answers opa % opb four cycles later
  logic [31:0] m_res;
  int          m_cnt;
  logic        m_busy;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_cnt <= 0; m_res <= '0; div_ostream_val <= 1'b0;
    end else if (!m_busy && div_istream_val && div_istream_rdy) begin
      m_busy <= 1'b1; m_cnt <= 4; m_res <= div_opa % div_opb;
    end else if (m_busy && !div_ostream_val) begin
      if (m_cnt == 1) div_ostream_val <= 1'b1;
      m_cnt <= m_cnt - 1;
    end else if (div_ostream_val && div_ostream_rdy) begin
      div_ostream_val <= 1'b0; m_busy <= 1'b0;
    end
  end
  assign div_result = m_res;

  always @(negedge clk) begin
    if (resp_val[1])      seen1     <= 1'b1;
    if (resp_val == 2'b11) seen_both <= 1'b1;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input int idx, input string tag);
    int n = 0;
    while (resp_val[idx] !== 1'b1 && n < 50) begin
      tick; n++;
    end
    chk(tag, 64'(n < 50), 64'd1);
  endtask

  initial begin
    reset = 1'b0; req_val = 2'b00; req_opa = '0; req_opb = '0;
    resp_rdy = 2'b11; div_istream_rdy = 1'b1; seen1 = 1'b0; seen_both = 1'b0;
    tick; tick;
    req_val = 2'b11; #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_div_iv", 64'(div_istream_val), 64'd0);
    chk("rst_div_ordy", 64'(div_ostream_rdy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    req_val = 2'b00;
    tick; reset = 1'b1; tick;

    // Single request from requester 0: 35 % 5 = 0
    req_val = 2'b01; req_opa[31:0] = 32'd35; req_opb[31:0] = 32'd5; #1;
    chk("t1_req_rdy", 64'(req_rdy), 64'd1);
    tick; req_val = 2'b00;
    chk("t1_div_iv", 64'(div_istream_val), 64'd1);
    chk("t1_div_opa", 64'(div_opa), 64'd35);
    chk("t1_div_opb", 64'(div_opb), 64'd5);
    wait_resp(0, "t1_resp_timeout");
    chk("t1_result", 64'(resp_result), 64'd0);
    chk("t1_owner", 64'(owner), 64'd0);
    tick;
    chk("t1_pulse_end", 64'(resp_val), 64'd0);
    chk("t1_no_resp1", 64'(seen1), 64'd0);

    // Tie after reset: requester 0 first (7%3=1), then requester 1 (9%2=1)
    reset = 1'b0; tick; reset = 1'b1; tick;
    req_val = 2'b11; req_opa = {32'd9, 32'd7}; req_opb = {32'd2, 32'd3}; #1;
    chk("t2_grant0", 64'(req_rdy), 64'd1);
    tick; req_val = 2'b10;
    wait_resp(0, "t2_resp0_timeout");
    chk("t2_result0", 64'(resp_result), 64'd1);
    chk("t2_owner0", 64'(owner), 64'd0);
    tick;
    chk("t2_grant1", 64'(req_rdy), 64'd2);
    tick; req_val = 2'b00;
    wait_resp(1, "t2_resp1_timeout");
    chk("t2_result1", 64'(resp_result), 64'd1);
    chk("t2_owner1", 64'(owner), 64'd1);
    tick;

    // Requester 1 back to back: 10%4=2, 11%4=3
    req_val = 2'b10; req_opa[63:32] = 32'd10; req_opb[63:32] = 32'd4; #1;
    chk("t3_grant_a", 64'(req_rdy), 64'd2);
    tick; req_opa[63:32] = 32'd11;
    wait_resp(1, "t3_resp_a_timeout");
    chk("t3_result_a", 64'(resp_result), 64'd2);
    tick;
    chk("t3_grant_b", 64'(req_rdy), 64'd2);
    tick; req_val = 2'b00;
    wait_resp(1, "t3_resp_b_timeout");
    chk("t3_result_b", 64'(resp_result), 64'd3);
    tick;

    // Response backpressure: 20%7=6 held five cycles while requester 1 waits
    resp_rdy = 2'b00;
    req_val = 2'b01; req_opa = {32'd13, 32'd20}; req_opb = {32'd5, 32'd7}; #1;
    chk("t4_grant0", 64'(req_rdy), 64'd1);
    tick; req_val = 2'b10;
    wait_resp(0, "t4_resp_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_val", 64'(resp_val), 64'd1);
      chk("t4_hold_res", 64'(resp_result), 64'd6);
      chk("t4_no_rdy", 64'(req_rdy), 64'd0);
      tick;
    end
    resp_rdy = 2'b11; tick;
    chk("t4_grant1", 64'(req_rdy), 64'd2);
    tick; req_val = 2'b00;
    wait_resp(1, "t4_resp1_timeout");
    chk("t4_result1", 64'(resp_result), 64'd3);
    tick;

    // Divider input stall: 100%7=2, operands stable while stalled
    div_istream_rdy = 1'b0;
    req_val = 2'b01; req_opa[31:0] = 32'd100; req_opb[31:0] = 32'd7;
    tick; req_val = 2'b00; req_opa[31:0] = 32'd55; req_opb[31:0] = 32'd1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_iv_held", 64'(div_istream_val), 64'd1);
      chk("t5_opa", 64'(div_opa), 64'd100);
      chk("t5_opb", 64'(div_opb), 64'd7);
      tick;
    end
    div_istream_rdy = 1'b1;
    wait_resp(0, "t5_resp_timeout");
    chk("t5_result", 64'(resp_result), 64'd2);
    tick;

    // Reset while waiting on the divider, then a tie goes to requester 0
    req_val = 2'b01; req_opa[31:0] = 32'd50; req_opb[31:0] = 32'd9;
    tick; req_val = 2'b00;
    tick;
    chk("t6_in_wait", 64'(div_ostream_rdy), 64'd1);
    reset = 1'b0; req_val = 2'b11; #1;
    chk("t6_rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("t6_rst_resp_val", 64'(resp_val), 64'd0);
    chk("t6_rst_iv", 64'(div_istream_val), 64'd0);
    chk("t6_rst_ordy", 64'(div_ostream_rdy), 64'd0);
    chk("t6_rst_opa", 64'(div_opa), 64'd0);
    chk("t6_rst_owner", 64'(owner), 64'd0);
    tick; tick; reset = 1'b1; #1;
    chk("t6_grant0", 64'(req_rdy), 64'd1);
    tick; req_val = 2'b00;
    wait_resp(0, "t6_resp_timeout");
    chk("t6_result", 64'(resp_result), 64'd5);
    chk("t6_owner", 64'(owner), 64'd0);
    tick;
    chk("never_both_resp", 64'(seen_both), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
